// File: rtl/dff_pipe_if.sv
// Handshake bundle for the dff_pipe delay line.
// Master drives the input word and controls; slave returns the pipe state.
interface dff_pipe_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             i_en;
  logic             i_flush;
  logic             i_vld;
  logic [WIDTH-1:0] i_d;
  logic [WIDTH-1:0] o_q;
  logic             o_vld;
  logic [CW-1:0]    o_cnt;
  logic             o_empty;
  logic             o_full;

  modport master (
    output i_en, i_flush, i_vld, i_d,
    input  o_q, o_vld, o_cnt, o_empty, o_full
  );

  modport slave (
    input  i_en, i_flush, i_vld, i_d,
    output o_q, o_vld, o_cnt, o_empty, o_full
  );
endinterface

// File: rtl/dff_pipe.sv
// Parametrised DFF delay line: DEPTH stages of data+valid,
// with global stall, synchronous flush and a running occupancy count.
module dff_pipe #(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic       i_clk,
  input  logic       i_rst,
  dff_pipe_if.slave  bus
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] vld_d;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;

  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    cnt_d  = cnt_q;
    if (bus.i_en) begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        data_d[k] = data_q[k-1];
        vld_d[k]  = vld_q[k-1];
      end
      data_d[0] = bus.i_d;
      vld_d[0]  = bus.i_vld;
      cnt_d = cnt_q + CW'(bus.i_vld) - CW'(vld_q[DEPTH-1]);
    end
    // Flush kills meaning, not data: registers keep shifting if enabled.
    if (bus.i_flush) begin
      vld_d = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        data_q[k] <= RST_VAL;
      end
      vld_q <= '0;
      cnt_q <= '0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.o_q     = data_q[DEPTH-1];
  assign bus.o_vld   = vld_q[DEPTH-1];
  assign bus.o_cnt   = cnt_q;
  assign bus.o_empty = (cnt_q == '0);
  assign bus.o_full  = (cnt_q == CW'(DEPTH));
endmodule

// File: tb/tb_dff_pipe.sv
// Self-checking bench for dff_pipe (WIDTH=8, DEPTH=4, RST_VAL=0).
// Reference model is a queue of {valid,data} entries, newest first.
module tb_dff_pipe;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam logic [WIDTH-1:0] RST_VAL = 8'h00;

  logic i_clk = 1'b0;
  logic i_rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  dff_pipe_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  dff_pipe #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .RST_VAL(RST_VAL)
  ) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .bus  (bus)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic             v;
    logic [WIDTH-1:0] d;
  } ent_t;

  ent_t mq[$];

  logic [13:0] act;
  assign act = {bus.o_q, bus.o_vld, bus.o_cnt,
                bus.o_empty, bus.o_full};

  function automatic void mreset();
    ent_t e;
    e.v = 1'b0;
    e.d = RST_VAL;
    mq.delete();
    repeat (DEPTH) mq.push_back(e);
  endfunction

  function automatic logic [13:0] mview();
    int c = 0;
    foreach (mq[i]) if (mq[i].v) c++;
    return {mq[DEPTH-1].d, mq[DEPTH-1].v, 3'(c),
            c == 0, c == DEPTH};
  endfunction

  task automatic tick(input logic en, input logic fl,
                      input logic v, input logic [7:0] d);
    ent_t e;
    bus.i_en    = en;
    bus.i_flush = fl;
    bus.i_vld   = v;
    bus.i_d     = d;
    @(posedge i_clk);
    if (en) begin
      e.v = v;
      e.d = d;
      mq.push_front(e);
      void'(mq.pop_back());
    end
    if (fl) foreach (mq[i]) mq[i].v = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    logic [13:0] exp_rst;
    exp_rst = {RST_VAL, 1'b0, 3'd0, 1'b1, 1'b0};
    bus.i_en = 0; bus.i_flush = 0; bus.i_vld = 0; bus.i_d = '0;
    #1 i_rst = 1'b1;
    #1;
    mreset();
    n_tests++;
    if (act !== exp_rst) begin
      n_fail++;
      $display("FAIL reset_por got=%h exp=%h", act, exp_rst);
    end
    #1 i_rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) tick(1, 0, 1, 8'hC0 + 8'(i));
    n_tests++;
    if (bus.o_full !== 1'b1 || bus.o_cnt !== 3'd4) begin
      n_fail++;
      $display("FAIL reset_fill got=%h exp full cnt=4", act);
    end
    #2 i_rst = 1'b1;
    #1;
    mreset();
    n_tests++;
    if (act !== exp_rst) begin
      n_fail++;
      $display("FAIL reset_async got=%h exp=%h", act, exp_rst);
    end
    #2 i_rst = 1'b0;
  endtask

  task automatic test_streaming();
    logic [7:0] din [8];
    din = '{8'h11, 8'h22, 8'h33, 8'h44,
            8'h55, 8'h66, 8'h77, 8'h88};
    for (int k = 0; k < 8; k++) begin
      tick(1, 0, 1, din[k]);
      n_tests++;
      if (act !== mview()) begin
        n_fail++;
        $display("FAIL stream_model k=%0d got=%h exp=%h",
                 k, act, mview());
      end
      n_tests++;
      if (bus.o_cnt !== 3'((k + 1 > 4) ? 4 : k + 1)
          || bus.o_vld !== (k >= 3)
          || (k >= 3 && bus.o_q !== din[k-3])
          || bus.o_full !== (k >= 3)) begin
        n_fail++;
        $display("FAIL stream_const k=%0d got=%h", k, act);
      end
    end
  endtask

  task automatic test_stall();
    logic [7:0] exp_q;
    for (int i = 0; i < 4; i++) tick(1, 0, 1, 8'hA0 + 8'(i));
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 1, 8'hFF);
      n_tests++;
      if (bus.o_q !== 8'hA0 || bus.o_vld !== 1'b1
          || bus.o_cnt !== 3'd4 || act !== mview()) begin
        n_fail++;
        $display("FAIL stall_hold i=%0d got=%h exp q=a0 cnt=4",
                 i, act);
      end
    end
    for (int i = 1; i < 4; i++) begin
      tick(1, 0, 1, 8'h5A);
      exp_q = 8'hA0 + 8'(i);
      n_tests++;
      if (bus.o_q !== exp_q || act !== mview()) begin
        n_fail++;
        $display("FAIL stall_resume i=%0d got=%h exp q=%h",
                 i, bus.o_q, exp_q);
      end
    end
  endtask

  task automatic test_bubbles();
    logic [7:0] din [4];
    logic       vin [4];
    din = '{8'h01, 8'h02, 8'h03, 8'h04};
    vin = '{1'b1, 1'b0, 1'b1, 1'b0};
    tick(0, 1, 0, 8'h00);
    for (int k = 0; k < 8; k++) begin
      if (k < 4) tick(1, 0, vin[k], din[k]);
      else tick(1, 0, 0, 8'h00);
      n_tests++;
      if (act !== mview() || bus.o_cnt > 3'd2) begin
        n_fail++;
        $display("FAIL bubble k=%0d got=%h exp=%h",
                 k, act, mview());
      end
      if (k >= 3 && k <= 6) begin
        n_tests++;
        if (bus.o_vld !== vin[k-3]
            || (vin[k-3] && bus.o_q !== din[k-3])) begin
          n_fail++;
          $display("FAIL bubble_out k=%0d got q=%h v=%b",
                   k, bus.o_q, bus.o_vld);
        end
      end
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 4; i++) tick(1, 0, 1, 8'h30 + 8'(i));
    tick(1, 1, 1, 8'h77);
    n_tests++;
    if (bus.o_cnt !== 3'd0 || bus.o_vld !== 1'b0
        || bus.o_empty !== 1'b1 || act !== mview()) begin
      n_fail++;
      $display("FAIL flush got=%h exp cnt=0 vld=0 empty=1", act);
    end
    for (int i = 0; i < 5; i++) begin
      tick(1, 0, 0, 8'h00);
      n_tests++;
      if (bus.o_vld !== 1'b0 || act !== mview()) begin
        n_fail++;
        $display("FAIL flush_drain i=%0d got=%h exp=%h",
                 i, act, mview());
      end
    end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 1000; i++) begin
      tick(($urandom % 10) < 7, ($urandom % 20) == 0,
           1'($urandom), 8'($urandom));
      n_tests++;
      if (act !== mview()) begin
        n_fail++;
        bad++;
        if (bad < 10)
          $display("FAIL random i=%0d got=%h exp=%h",
                   i, act, mview());
      end
    end
  endtask

  initial begin
    mreset();
    test_reset();
    test_streaming();
    test_stall();
    test_bubbles();
    test_flush();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/dff_pipe.md
Name: dff_pipe

Overview:
- Parametrised multi-stage D-flip-flop delay line: the successor to the single-bit latch/DFF cells.
- Carries a WIDTH-bit data word plus a valid bit through DEPTH register stages.
- Supports global stall (enable), synchronous flush and a running occupancy count.
- Used as a generic retiming/alignment pipe between datapath blocks.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 4, number of register stages = latency in enabled cycles (>=1).
- RST_VAL, 0, reset value loaded into every data stage (WIDTH bits).

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst  input  1  reset, asynchronous, active-high.
- i_en  input  1  advance enable; 1 = all stages shift one position, 0 = all stages hold.
- i_flush  input  1  synchronous flush; clears all valid bits.
- i_vld  input  1  valid qualifier for i_d.
- i_d  input  WIDTH  input data word.
- o_q  output  WIDTH  data of last stage (DEPTH-1).
- o_vld  output  1  valid bit of last stage.
- o_cnt  output  $clog2(DEPTH+1)  number of stages currently holding valid data (0..DEPTH).
- o_empty  output  1  1 when o_cnt==0.
- o_full  output  1  1 when o_cnt==DEPTH.

Behaviour:
- Reset (i_rst=1, asynchronous, immediate, independent of i_clk):
  - all data stages = RST_VAL; all valid bits = 0.
  - o_cnt = 0, o_empty = 1, o_full = 0, o_q = RST_VAL, o_vld = 0.
- Reset deassertion: first update on the next rising edge with i_rst=0.
- Per rising edge, priority order: i_rst > i_flush > i_en > hold.
- i_flush=1 (regardless of i_en, i_vld):
  - all valid bits <- 0, o_cnt <- 0.
  - Data registers are NOT cleared; if i_en=1 they still shift, so o_q data may change while o_vld=0.
  - The word presented with i_flush is discarded.
- i_en=1, i_flush=0:
  - stage0.data <- i_d, stage0.vld <- i_vld.
  - stage k <- stage k-1 for k=1..DEPTH-1.
  - The old last stage is dropped; no back-pressure exists.
- i_en=0, i_flush=0: all stages and o_cnt hold; i_vld/i_d ignored.
- Data registers load irrespective of valid; only valid bits carry meaning.
- Latency: a word presented on edge N with i_en=1 appears on o_q/o_vld after DEPTH enabled edges.
  - With i_en held 1: visible after edge N+DEPTH-1, i.e. DEPTH cycles after presentation.
  - Stalled cycles add latency one-for-one.
- o_cnt is a registered counter, updated incrementally (not a popcount):
  - on an enabled shift: cnt_next = cnt + i_vld - vld[DEPTH-1].
  - simultaneous enter and exit leaves the count unchanged.
  - flush forces 0.
  - Counter never exceeds DEPTH or goes below 0 by construction; the bench asserts o_cnt == popcount(valid bits) every cycle.
- o_empty and o_full are combinational decodes of o_cnt.
- Every output is a register or a decode of registers; no combinational path from any input to any output.
- DEPTH=1 is a single registered stage with identical rules.

Test Plan (WIDTH=8, DEPTH=4, RST_VAL=0):
- Reset: assert i_rst mid-cycle with the pipe full → o_vld=0, o_cnt=0, o_empty=1, o_q=8'h00 immediately, before the next clock edge.
- Streaming: i_en=1, i_vld=1, i_d=8'h11,22,33,44,55 on consecutive edges → o_q=8'h11 with o_vld=1 after the 4th edge, then 22,33,44,55 on successive edges; o_cnt ramps 1,2,3,4 and stays 4; o_full=1.
- Stall: fill with 8'hA0..A3, hold i_en=0 for 3 cycles with i_d=8'hFF, i_vld=1 → outputs and o_cnt=4 frozen; on resume o_q continues A0→A1, and 8'hFF never appears.
- Bubbles: i_vld pattern 1,0,1,0 with data 01,02,03,04, i_en=1 → o_vld sequence 1,0,1,0 carrying 01,xx,03,xx; o_cnt peaks at 2 and never leaves 0..2.
- Flush: full pipe, assert i_flush with i_en=1, i_vld=1, i_d=8'h77 → next edge o_cnt=0, o_vld=0, o_empty=1; the 8'h77 word never emerges valid.
- Random: 1000 cycles of random i_en/i_vld/i_flush/i_d against a reference queue model → o_q/o_vld match, and o_cnt == popcount of valid bits every cycle.
